pragmatic_weight_encoder: RTL and testbench

PRAGMATIC_WEIGHT_ENCODER -- requirements
Module: pragmatic_weight_encoder

---
 rtl/pragmatic_weight_encoder_if.sv | 28 ++
 rtl/pragmatic_weight_encoder.sv | 142 ++++++++++++++
 tb/tb_pragmatic_weight_encoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pragmatic_weight_encoder_if.sv
// Weight-vector in / beat-stream out bundle for the Pragmatic weight encoder.
interface pragmatic_weight_encoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_in;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [VEC_LENGTH-1:0][IDX_W-1:0]      w_idx;
  logic [VEC_LENGTH-1:0]                 w_en;
  logic [VEC_LENGTH-1:0]                 is_neg;
  logic                                  first_beat;
  logic                                  last_beat;

  modport slave (
    input  in_valid, weight_in, out_ready,
    output in_ready, out_valid, w_idx, w_en, is_neg, first_beat, last_beat
  );

  modport master (
    output in_valid, weight_in, out_ready,
    input  in_ready, out_valid, w_idx, w_en, is_neg, first_beat, last_beat
  );
endinterface

// File: rtl/pragmatic_weight_encoder.sv
// Pragmatic weight encoder: splits each lane's |weight| into one power-of-two term per beat, MSB first.
// Optional saturating beat counter output enabled by PRAGMATIC_ENC_BEAT_CNT_EN.
module pwe_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_weight,
  output logic                  o_en,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_neg,
  output logic                  o_rem_zero
);
  logic                  r_sign;
  logic [DATA_WIDTH-1:0] r_mag;
  logic [DATA_WIDTH-1:0] w_abs;
  logic [DATA_WIDTH-1:0] w_rem;
  logic [IDX_W-1:0]      w_idx;

  // -128 wraps to 0x80, which is exactly the unsigned magnitude wanted
  assign w_abs = i_weight[DATA_WIDTH-1] ? (DATA_WIDTH'(0) - i_weight) : i_weight;

  always_comb begin
    w_idx = '0;
    for (int b = 0; b < DATA_WIDTH; b++)
      if (r_mag[b]) w_idx = b[IDX_W-1:0];
  end

  assign w_rem      = r_mag & ~({{(DATA_WIDTH-1){1'b0}}, 1'b1} << w_idx);
  assign o_en       = (r_mag != '0);
  assign o_idx      = w_idx;
  assign o_neg      = r_sign && o_en;
  assign o_rem_zero = (w_rem == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sign <= 1'b0;
      r_mag  <= '0;
    end else if (i_load) begin
      r_sign <= i_weight[DATA_WIDTH-1];
      r_mag  <= w_abs;
    end else if (i_step) begin
      r_mag  <= w_rem;
    end
  end
endmodule

module pragmatic_weight_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8
) (
  input  logic clk,
  input  logic reset,
  pragmatic_weight_encoder_if.slave bus
`ifdef PRAGMATIC_ENC_BEAT_CNT_EN
  ,
  output logic [31:0] beat_count
`endif
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {S_IDLE, S_ENCODE} state_t;

  state_t                           r_state, w_state_nxt;
  logic                             r_first;
  logic                             w_in_ready, w_out_valid, w_last;
  logic                             w_accept, w_step;
  logic [VEC_LENGTH-1:0]            w_en, w_neg, w_rem_zero;
  logic [VEC_LENGTH-1:0][IDX_W-1:0] w_idx;

  genvar g;
  generate
    for (g = 0; g < VEC_LENGTH; g++) begin : g_lane
      pwe_lane #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_lane (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_weight   (bus.weight_in[g]),
        .o_en       (w_en[g]),
        .o_idx      (w_idx[g]),
        .o_neg      (w_neg[g]),
        .o_rem_zero (w_rem_zero[g])
      );
    end
  endgenerate

  assign w_last   = (r_state == S_ENCODE) && (&w_rem_zero);
  assign w_step   = w_out_valid && bus.out_ready;
  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Accepting on the last beat reloads the lanes in the same edge, so vectors stream without a bubble
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_ENCODE;
      end
      S_ENCODE: begin
        w_out_valid = 1'b1;
        w_in_ready  = w_last && bus.out_ready;
        if (w_last && bus.out_ready)
          w_state_nxt = bus.in_valid ? S_ENCODE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_first <= 1'b0;
    else if (w_accept) r_first <= 1'b1;
    else if (w_step)   r_first <= 1'b0;
  end

`ifdef PRAGMATIC_ENC_BEAT_CNT_EN
  logic [31:0] r_beat_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           r_beat_count <= '0;
    else if (w_step && ~&r_beat_count)    r_beat_count <= r_beat_count + 32'd1;
  end
  assign beat_count = r_beat_count;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.w_idx      = w_idx;
  assign bus.w_en       = w_en;
  assign bus.is_neg     = w_neg;
  assign bus.first_beat = r_first;
  assign bus.last_beat  = w_last;
endmodule

// File: tb/tb_pragmatic_weight_encoder.sv
// Directed bench for pragmatic_weight_encoder: vector table plus stall, back-to-back and reset sequences.
module tb_pragmatic_weight_encoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pragmatic_weight_encoder_if #(.DATA_WIDTH(8), .VEC_LENGTH(8)) bus ();
`ifdef PRAGMATIC_ENC_BEAT_CNT_EN
  logic [31:0] beat_count;
`endif

  pragmatic_weight_encoder #(.DATA_WIDTH(8), .VEC_LENGTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PRAGMATIC_ENC_BEAT_CNT_EN
    ,
    .beat_count (beat_count)
`endif
  );

  typedef struct {
    logic [7:0][7:0] w;
    int              beats;
    logic [7:0][2:0] idx0;
    logic [7:0]      en0;
    logic [7:0]      neg0;
  } vec_t;

  vec_t tv [5];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int  beats;
    bit  done;
    int  acc [8];
    beats = 0;
    done  = 0;
    for (int l = 0; l < 8; l++) acc[l] = 0;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.weight_in = tv[i].w;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (beats == 0) begin
        chk($sformatf("v%0d latency", i), 64'(bus.out_valid), 64'd1);
        chk($sformatf("v%0d idx0", i), 64'(bus.w_idx), 64'(tv[i].idx0));
        chk($sformatf("v%0d en0", i), 64'(bus.w_en), 64'(tv[i].en0));
        chk($sformatf("v%0d neg0", i), 64'(bus.is_neg), 64'(tv[i].neg0));
      end
      if (bus.out_valid) begin
        chk($sformatf("v%0d first b%0d", i, beats), 64'(bus.first_beat), 64'(beats == 0));
        for (int l = 0; l < 8; l++)
          if (bus.w_en[l])
            acc[l] += bus.is_neg[l] ? -(1 << bus.w_idx[l]) : (1 << bus.w_idx[l]);
        beats++;
        if (bus.last_beat) done = 1;
      end
    end
    if (!done) chk($sformatf("v%0d timeout", i), 64'd0, 64'd1);
    chk($sformatf("v%0d beats", i), 64'(beats), 64'(tv[i].beats));
    for (int l = 0; l < 8; l++)
      chk($sformatf("v%0d sum l%0d", i, l), 64'(acc[l]), 64'(int'($signed(tv[i].w[l]))));
    @(negedge clk);
    chk($sformatf("v%0d idle vld", i), 64'(bus.out_valid), 64'd0);
    chk($sformatf("v%0d idle rdy", i), 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    tv[0] = '{w: {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, beats: 1,
              idx0: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, en0: 8'hFF, neg0: 8'h80};
    tv[1] = '{w: '0, beats: 1, idx0: '0, en0: 8'h00, neg0: 8'h00};
    tv[2] = '{w: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F}, beats: 7,
              idx0: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6}, en0: 8'h01, neg0: 8'h00};
    // {-1, 3, -7, 5, 0, 127, -127, -128}, lane 0 rightmost
    tv[3] = '{w: {8'h80, 8'h81, 8'h7F, 8'h00, 8'h05, 8'hF9, 8'h03, 8'hFF}, beats: 7,
              idx0: {3'd7, 3'd6, 3'd6, 3'd0, 3'd2, 3'd2, 3'd1, 3'd0}, en0: 8'hEF, neg0: 8'hC5};
    tv[4] = '{w: {8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, beats: 1,
              idx0: {3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, en0: 8'h80, neg0: 8'h80};

    bus.in_valid  = 1'b0;
    bus.weight_in = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst first", 64'(bus.first_beat), 64'd0);
    chk("rst last", 64'(bus.last_beat), 64'd0);
    chk("rst w_en", 64'(bus.w_en), 64'd0);
    chk("rst w_idx", 64'(bus.w_idx), 64'd0);
    chk("rst is_neg", 64'(bus.is_neg), 64'd0);
`ifdef PRAGMATIC_ENC_BEAT_CNT_EN
    chk("rst beat_count", 64'(beat_count), 64'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post rst in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Lane0 = -5 with the first beat stalled for two cycles
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.weight_in = {56'd0, 8'hFB};
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("stall vld c%0d", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall idx c%0d", c), 64'(bus.w_idx[0]), 64'd2);
      chk($sformatf("stall neg c%0d", c), 64'(bus.is_neg), 64'h01);
      chk($sformatf("stall first c%0d", c), 64'(bus.first_beat), 64'd1);
      chk($sformatf("stall last c%0d", c), 64'(bus.last_beat), 64'd0);
      if (c == 2) bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("stall b2 idx", 64'(bus.w_idx[0]), 64'd0);
    chk("stall b2 neg", 64'(bus.is_neg), 64'h01);
    chk("stall b2 first", 64'(bus.first_beat), 64'd0);
    chk("stall b2 last", 64'(bus.last_beat), 64'd1);
    @(negedge clk);
    chk("stall done vld", 64'(bus.out_valid), 64'd0);

    // Back-to-back: {3,...} then {1,...} with in_valid held
    bus.in_valid  = 1'b1;
    bus.weight_in = {56'd0, 8'h03};
    @(negedge clk);
    chk("b2b v1 b1 idx", 64'(bus.w_idx[0]), 64'd1);
    chk("b2b v1 b1 rdy", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("b2b v1 b2 idx", 64'(bus.w_idx[0]), 64'd0);
    chk("b2b v1 b2 last", 64'(bus.last_beat), 64'd1);
    chk("b2b v1 b2 rdy", 64'(bus.in_ready), 64'd1);
    bus.weight_in = {56'd0, 8'h01};
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b v2 vld", 64'(bus.out_valid), 64'd1);
    chk("b2b v2 first", 64'(bus.first_beat), 64'd1);
    chk("b2b v2 last", 64'(bus.last_beat), 64'd1);
    chk("b2b v2 en", 64'(bus.w_en), 64'h01);
    @(negedge clk);
    chk("b2b idle", 64'(bus.out_valid), 64'd0);

    // Reset during beat 2 of a 0x7F vector
    bus.in_valid  = 1'b1;
    bus.weight_in = {56'd0, 8'h7F};
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid b2 idx", 64'(bus.w_idx[0]), 64'd5);
    #2 reset = 1'b0;
    #1;
    chk("mid rst vld", 64'(bus.out_valid), 64'd0);
    chk("mid rst en", 64'(bus.w_en), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid rel rdy", 64'(bus.in_ready), 64'd1);
`ifdef PRAGMATIC_ENC_BEAT_CNT_EN
    chk("mid rel beat_count", 64'(beat_count), 64'd0);
`endif
    repeat (3) begin
      @(negedge clk);
      chk("mid no beats", 64'(bus.out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
